// File: rtl/sum4_seq_ctrl.sv
// Nibble-serial adder controller driving one shared 4-bit CLA (sum4).
// Operands are added LSB nibble first; the carry ripples through carry_q.
module sum4_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_s,
  input  logic             add_cout
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = $clog2(NIB);
  localparam int PW  = 4 * (NIB - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [PW-1:0]    p_q, p_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      p_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      p_q     <= p_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign last = (idx_q == IW'(NIB - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    p_d     = p_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int k = 0; k < NIB; k++) begin
          if (idx_q == IW'(k)) begin
            add_a = a_q[4*k +: 4];
            add_b = b_q[4*k +: 4];
          end
        end
        add_cin = carry_q;
        for (int k = 0; k < NIB - 1; k++) begin
          if (idx_q == IW'(k)) p_d[4*k +: 4] = add_s;
        end
        carry_d = add_cout;
        idx_d   = idx_q + 1'b1;
        if (last) begin
          sum_d   = {add_s, p_q};
          cout_d  = add_cout;
          // Overflow: like-signed operands yielding a result of the other sign.
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (add_s[3] != a_q[WIDTH-1]);
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_sum4_seq_ctrl.sv
// Self-checking bench for sum4_seq_ctrl with a behavioural sum4 attached.
module tb_sum4_seq_ctrl;

  logic        clk, rst_n, start, cin;
  logic [15:0] a, b;
  logic        busy, done, cout, ovf;
  logic [15:0] sum;
  logic [3:0]  add_a, add_b, add_s;
  logic        add_cin, add_cout;

  int checks = 0;
  int failures = 0;

  sum4_seq_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum),
    .cout(cout), .ovf(ovf),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout)
  );

  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Pulse start for one accepting edge, then wait for done.
  task automatic do_op(input logic [15:0] av, input logic [15:0] bv,
                       input logic cv, input logic hold, output int lat);
    @(negedge clk);
    a = av; b = bv; cin = cv; start = 1;
    @(posedge clk);
    #1;
    @(negedge clk);
    if (!hold) start = 0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
    end
  endtask

  vec_t vecs[8];
  int lat;
  int npulse;

  initial begin
    vecs[0] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[5] = '{16'h5555, 16'hAAAA, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vecs[6] = '{16'h0FFF, 16'h0001, 1'b1, 16'h1001, 1'b0, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

    rst_n = 0; start = 0; a = 0; b = 0; cin = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_add_a", add_a, 0);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, lat);
      chk($sformatf("v%0d_latency", i), lat, 4);
      chk($sformatf("v%0d_busy", i), busy, 1);
      chk($sformatf("v%0d_sum", i), sum, vecs[i].s);
      chk($sformatf("v%0d_cout", i), cout, vecs[i].co);
      chk($sformatf("v%0d_ovf", i), ovf, vecs[i].ov);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_1cyc", i), done, 0);
      chk($sformatf("v%0d_idle", i), busy, 0);
      chk($sformatf("v%0d_sum_hold", i), sum, vecs[i].s);
    end

    // Start pulses and operand changes during RUN must be ignored.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 0; start = 1;
    @(negedge clk);
    start = 0; a = 16'hF0F0; b = 16'h0F0F; cin = 1;
    @(negedge clk);
    start = 1; a = 16'h0000;
    @(negedge clk);
    start = 0;
    chk("ign_sum_stable", sum, 16'h0000);
    npulse = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        npulse++;
        chk("ign_sum", sum, 16'h3333);
        chk("ign_cout", cout, 0);
      end
    end
    chk("ign_npulse", npulse, 1);

    // Start held high: re-accepted right after the IDLE cycle.
    do_op(16'h0102, 16'h0304, 1'b0, 1'b1, lat);
    chk("hold_lat1", lat, 4);
    chk("hold_sum1", sum, 16'h0406);
    @(negedge clk);
    a = 16'h00FF; b = 16'h0001;
    @(posedge clk);
    #1;
    chk("hold_idle", busy, 0);
    @(posedge clk);
    #1;
    chk("hold_reaccept", busy, 1);
    @(negedge clk);
    start = 0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
    end
    chk("hold_lat2", lat, 4);
    chk("hold_sum2", sum, 16'h0100);

    // Asynchronous reset two edges into RUN.
    @(negedge clk);
    a = 16'h9999; b = 16'h9999; cin = 0; start = 1;
    @(posedge clk);
    #1;
    @(negedge clk);
    start = 0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_sum", sum, 0);
    chk("arst_cout", cout, 0);
    chk("arst_ovf", ovf, 0);
    npulse = 0;
    @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (done) npulse++;
    end
    chk("arst_no_done", npulse, 0);
    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, lat);
    chk("post_rst_lat", lat, 4);
    chk("post_rst_sum", sum, 16'h5555);
    chk("post_rst_cout", cout, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
